// File: rtl/mdio_pkg.sv
// ----------------------------------------------------------------------------
// mdio_pkg: Clause-22 MDIO frame constants, FSM state type, header builder. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int MDIO_PRE_BITS   = 32;
  localparam int MDIO_FRAME_BITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4,
    ST_RESP = 3'd5
  } mdio_state_e;

  // Post-preamble part of the frame; read TA/DATA positions are never driven.
  function automatic logic [31:0] mdio_hdr(input logic       write,
                                           input logic [4:0] phy_addr,
                                           input logic [4:0] reg_addr,
                                           input logic [15:0] wdata);
    return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phy_addr, reg_addr,
            (write ? 2'b10 : 2'b11), (write ? wdata : 16'hFFFF)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_clk_gen.sv
// ----------------------------------------------------------------------------
// mdio_clk_gen: MDC generator with bit-start (fall) and sample (rise) strobes. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic mdc,
  output logic bit_start,
  output logic sample
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic             wrap;

  assign wrap = run && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    mdc_d = mdc_q;
    if (!run) begin
      div_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      div_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign bit_start = wrap && mdc_q;
  assign sample    = wrap && !mdc_q;

endmodule

`default_nettype wire

// File: rtl/mdio_master.sv
// ----------------------------------------------------------------------------
// mdio_master: Clause-22 MDIO read/write master; MDIO_TA_CHECK_EN enables TA error. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST  = 6'(MDIO_PRE_BITS - 1);
  localparam logic [5:0] HDR_LAST  = 6'd45;
  localparam logic [5:0] TA_LAST   = 6'd47;
  localparam logic [5:0] FRAME_LAST = 6'(MDIO_FRAME_BITS - 1);

  mdio_state_e state_q, state_d;
  logic        run, bit_start, sample, accept, last_bit;
  logic [5:0]  bitcnt_q;
  logic        write_q;
  logic [31:0] tx_q;
  logic [15:0] rx_q, rdata_q;
  logic        mdio_o_q, mdio_oe_q;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mdc       (mdc),
    .bit_start (bit_start),
    .sample    (sample)
  );

  assign accept   = req_valid && req_ready;
  assign last_bit = bit_start && (bitcnt_q == FRAME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PRE;
      ST_PRE:  if (bit_start && bitcnt_q == PRE_LAST) state_d = ST_HDR;
      ST_HDR:  if (bit_start && bitcnt_q == HDR_LAST) state_d = ST_TA;
      ST_TA:   if (bit_start && bitcnt_q == TA_LAST) state_d = ST_DATA;
      ST_DATA: if (last_bit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    run       = (state_q == ST_PRE) || (state_q == ST_HDR) ||
                (state_q == ST_TA)  || (state_q == ST_DATA);
  end

  // The first preamble bit is loaded at accept since MDC is already low there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q  <= '0;
      write_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
    end else begin
      if (accept) begin
        bitcnt_q  <= '0;
        write_q   <= req_write;
        tx_q      <= mdio_hdr(req_write, req_phy_addr, req_reg_addr, req_wdata);
        rx_q      <= '0;
        mdio_o_q  <= 1'b1;
        mdio_oe_q <= 1'b1;
      end else if (run && bit_start) begin
        if (last_bit) begin
          bitcnt_q  <= '0;
          mdio_o_q  <= 1'b1;
          mdio_oe_q <= 1'b0;
          rdata_q   <= write_q ? 16'h0000 : rx_q;
        end else begin
          bitcnt_q  <= bitcnt_q + 6'd1;
          mdio_oe_q <= write_q || (bitcnt_q < HDR_LAST);
          if (bitcnt_q >= PRE_LAST) begin
            mdio_o_q <= tx_q[31];
            tx_q     <= {tx_q[30:0], 1'b0};
          end else begin
            mdio_o_q <= 1'b1;
          end
        end
      end
      if (run && sample && !write_q && bitcnt_q > TA_LAST) begin
        rx_q <= {rx_q[14:0], mdio_i};
      end
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign rsp_rdata = rdata_q;

`ifdef MDIO_TA_CHECK_EN
  logic ta_err_q, rsp_err_q;

  // A 1 on the second TA bit means nobody pulled the line low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ta_err_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) ta_err_q <= 1'b0;
      else if (run && sample && !write_q && bitcnt_q == TA_LAST) ta_err_q <= mdio_i;
      if (run && last_bit) rsp_err_q <= ta_err_q && !write_q;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdio_master.sv
// ----------------------------------------------------------------------------
// tb_mdio_master: frame-level model plus directed MDIO read/write scenarios. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mdio_master;

  localparam int CD        = 4;
  localparam int FRAME_CYC = 128 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy_addr = '0;
  logic [4:0]  req_reg_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;

  mdio_master #(.CLK_DIV(CD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_phy_addr (req_phy_addr),
    .req_reg_addr (req_reg_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mdc          (mdc),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .mdio_i       (mdio_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position in frame derived from cycles since accept.
  int          off = -1;
  int          cyc = 0;
  logic [63:0] m_frame;
  logic        m_wr;
  logic [15:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        phy_present = 1'b1;
  logic [15:0] phy_data = '0;
  logic [63:0] cap = '0;
  logic        prev_mdc = 1'b0;
  int          mdc_hi = 0;
  int          oe_lo = 0;
  int          n_rsp = 0;
  int          acc_q[$];
  int          rsp_q[$];

  always @(negedge clk) begin
    int  k, ph;
    bit  resp_now;
    cyc++;
    resp_now = 1'b0;
    if (!rst_n) begin
      chk("rst_ready", req_ready, 1);   chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);   chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);         chk("rst_mdc", mdc, 0);
      chk("rst_mdio_o", mdio_o, 1);     chk("rst_mdio_oe", mdio_oe, 0);
      off = -1; m_rdata = '0; m_err = 1'b0; mdio_i = 1'b1;
    end else begin
      if (off >= 0) off++;
      if (off < 0) begin
        chk("idle_ready", req_ready, 1);  chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_mdc", mdc, 0);          chk("idle_mdio_o", mdio_o, 1);
        chk("idle_mdio_oe", mdio_oe, 0);
        chk("idle_rdata", rsp_rdata, m_rdata); chk("idle_err", rsp_err, m_err);
      end else if (off <= FRAME_CYC) begin
        k  = (off - 1) / (2 * CD);
        ph = (off - 1) % (2 * CD);
        chk("frm_ready", req_ready, 0);   chk("frm_busy", busy, 1);
        chk("frm_rsp_valid", rsp_valid, 0);
        chk("frm_mdc", mdc, (ph >= CD) ? 1 : 0);
        chk("frm_mdio_oe", mdio_oe, (m_wr || k < 46) ? 1 : 0);
        if (m_wr || k < 46) chk("frm_mdio_o", mdio_o, m_frame[63-k]);
        if (!mdio_oe) oe_lo++;
        if (!m_wr && phy_present)
          mdio_i = (k == 47) ? 1'b0 : (k >= 48) ? phy_data[63-k] : 1'b1;
        else
          mdio_i = 1'b1;
      end else begin
        resp_now = 1'b1;
        m_rdata = m_wr ? 16'h0000 : (phy_present ? phy_data : 16'hFFFF);
`ifdef MDIO_TA_CHECK_EN
        m_err = !m_wr && !phy_present;
`else
        m_err = 1'b0;
`endif
        chk("resp_valid", rsp_valid, 1);  chk("resp_rdata", rsp_rdata, m_rdata);
        chk("resp_err", rsp_err, m_err);  chk("resp_busy", busy, 1);
        chk("resp_ready", req_ready, 0);  chk("resp_mdc", mdc, 0);
        chk("resp_mdio_o", mdio_o, 1);    chk("resp_mdio_oe", mdio_oe, 0);
        off = -1;
        mdio_i = 1'b1;
      end
      if (off < 0 && !resp_now && req_valid) begin
        m_wr    = req_write;
        m_frame = {32'hFFFF_FFFF, 2'b01, (req_write ? 2'b01 : 2'b10), req_phy_addr,
                   req_reg_addr, 2'b10, req_wdata};
        off = 0;
        acc_q.push_back(cyc);
      end
    end
    if (mdc && !prev_mdc) cap = {cap[62:0], mdio_o};
    if (mdc) mdc_hi++;
    prev_mdc = mdc;
    if (rsp_valid) begin
      n_rsp++;
      rsp_q.push_back(cyc);
    end
  end

  task automatic start_req(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] data);
    @(posedge clk); #1;
    req_write = wr; req_phy_addr = phy; req_reg_addr = rg; req_wdata = data;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~wr; req_phy_addr = 5'h1F; req_reg_addr = 5'h15; req_wdata = 16'hDEAD;
  endtask

  task automatic wait_rsp(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("lit_reset_ready", req_ready, 1);
    chk("lit_reset_mdio_o", mdio_o, 1);
    chk("lit_reset_rdata", rsp_rdata, 0);

    // Write phy=1 reg=0 data=0x1140
    mdc_hi = 0; oe_lo = 0;
    start_req(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp("wr");
    @(negedge clk); #1;
    chk("lit_wr_latency", rsp_q[$] - acc_q[$], 513);
    chk("lit_wr_bits", cap, {32'hFFFF_FFFF, 32'h5082_1140});
    chk("lit_wr_mdc_high_cycles", mdc_hi, 256);
    chk("lit_wr_oe_low_cycles", oe_lo, 0);
    chk("lit_wr_rdata", rsp_rdata, 16'h0000);

    // Read phy=1 reg=2, PHY returns 0x001C
    phy_present = 1'b1; phy_data = 16'h001C; oe_lo = 0;
    start_req(1'b0, 5'd1, 5'd2, 16'h0000);
    wait_rsp("rd");
    @(negedge clk); #1;
    chk("lit_rd_hdr_bits", cap[63:18], {32'hFFFF_FFFF, 14'b01_10_00001_00010});
    chk("lit_rd_oe_low_cycles", oe_lo, 144);
    chk("lit_rd_rdata", rsp_rdata, 16'h001C);
    chk("lit_rd_err", rsp_err, 0);

    // PHY absent: bus floats high through TA and DATA
    phy_present = 1'b0;
    start_req(1'b0, 5'd3, 5'd1, 16'h0000);
    wait_rsp("ta");
    @(negedge clk); #1;
    chk("lit_ta_rdata", rsp_rdata, 16'hFFFF);
`ifdef MDIO_TA_CHECK_EN
    chk("lit_ta_err", rsp_err, 1);
`else
    chk("lit_ta_err", rsp_err, 0);
`endif
    phy_present = 1'b1;

    // Back-to-back: write then read with req_valid held high
    phy_data = 16'hBEEF;
    @(posedge clk); #1;
    req_write = 1'b1; req_phy_addr = 5'd2; req_reg_addr = 5'd4; req_wdata = 16'hA5A5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b0; req_phy_addr = 5'd5; req_reg_addr = 5'd3; req_wdata = 16'h0000;
    wait_rsp("b2b_wr");
    @(posedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lit_b2b_gap", acc_q[$] - rsp_q[$], 1);
    wait_rsp("b2b_rd");
    @(negedge clk); #1;
    chk("lit_b2b_rdata", rsp_rdata, 16'hBEEF);
    chk("lit_b2b_hdr_bits", cap[63:18], {32'hFFFF_FFFF, 14'b01_10_00101_00011});

    // Reset asserted during bit 40 of a read
    phy_data = 16'h1234;
    start_req(1'b0, 5'd1, 5'd2, 16'h0000);
    for (int i = 0; i < 2 * FRAME_CYC && off < 1 + 2 * 40 * CD + 2; i++) @(negedge clk);
    chk("lit_mid_bit_reached", (off >= 1 + 2 * 40 * CD + 2) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_mdc", mdc, 0);
    chk("lit_async_oe", mdio_oe, 0);
    chk("lit_async_busy", busy, 0);
    begin
      int rsp_before;
      rsp_before = n_rsp;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (FRAME_CYC + 10) @(negedge clk);
      chk("lit_no_rsp_after_reset", n_rsp, rsp_before);
    end

    // Normal operation after reset
    start_req(1'b1, 5'd7, 5'd31, 16'h8001);
    wait_rsp("post_wr");
    @(negedge clk); #1;
    chk("lit_post_wr_bits", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd31, 2'b10, 16'h8001});
    phy_data = 16'h5A5A;
    start_req(1'b0, 5'd7, 5'd31, 16'h0000);
    wait_rsp("post_rd");
    @(negedge clk); #1;
    chk("lit_post_rd_rdata", rsp_rdata, 16'h5A5A);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
